// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: assembles little-endian 32-bit words and writes them to instruction memory.
// Optional macro LOADER_CHECKSUM_EN appends a trailing XOR checksum byte and a chk_err output.
module instr_mem_loader #(
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] word_count,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        busy,
    output logic        done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic        chk_err
`endif
);
    localparam logic [10:0] MAX_CNT = 11'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] count_q, count_d;
    logic [10:0] word_idx_q, word_idx_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wd_q, wd_d;
    logic        we_c;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
    logic        chk_err_q, chk_err_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            lane_q     <= '0;
            wd_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
            chk_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            lane_q     <= lane_d;
            wd_q       <= wd_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
            chk_err_q  <= chk_err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        lane_d     = lane_q;
        wd_d       = wd_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d      = xor_q;
        chk_err_d  = chk_err_q;
`endif
        byte_ready = 1'b0;
        we_c       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d    = (word_count > MAX_CNT) ? MAX_CNT : word_count;
                    word_idx_d = '0;
                    lane_d     = '0;
`ifdef LOADER_CHECKSUM_EN
                    xor_d      = '0;
                    chk_err_d  = 1'b0;
`endif
                    state_d    = (word_count == 11'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    wd_d[{lane_q, 3'b000} +: 8] = byte_data;
                    lane_d = lane_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    xor_d  = xor_q ^ byte_data;
`endif
                    if (lane_q == 2'd3)
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                we_c   = 1'b1;
                lane_d = '0;
                // Index wraps to 0 on the last word so mem_addr never leaves the array.
                if (word_idx_q + 11'd1 == count_q) begin
                    word_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    state_d    = S_CHECK;
`else
                    state_d    = S_DONE;
`endif
                end else begin
                    word_idx_d = word_idx_q + 11'd1;
                    state_d    = S_LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    chk_err_d = (byte_data != xor_q);
                    state_d   = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done       = 1'b1;
                word_idx_d = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset suppresses a write strobe that would otherwise coincide with it.
    assign mem_we   = we_c & ~rst;
    assign mem_addr = {3'b000, word_idx_q, 2'b00};
    assign mem_wd   = wd_q;
    assign busy     = (state_q != S_IDLE);
`ifdef LOADER_CHECKSUM_EN
    assign chk_err  = chk_err_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader with a transaction-level reference model and literal spot checks.
// Honours LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_instr_mem_loader;
    localparam int MAXW = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] word_count = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, mem_we, busy, done;
    logic [15:0] mem_addr;
    logic [31:0] mem_wd;
`ifdef LOADER_CHECKSUM_EN
    logic        chk_err;
`endif

    instr_mem_loader #(.MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .busy(busy), .done(done)
`ifdef LOADER_CHECKSUM_EN
        , .chk_err(chk_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: ph 0 idle, 1 collecting bytes, 2 writing, 3 checksum byte, 4 done pulse
    int          ph = 0;
    int          m_cnt = 0;
    int          m_widx = 0;
    logic [7:0]  m_bytes[$];
    logic [7:0]  m_xor = '0;
    logic        m_chk = 1'b0;
    bit          m_acc = 1'b0;

    // Observation log used by the literal checks
    int          we_addrs[$];
    logic [31:0] we_datas[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          start_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (cyc >= 1) begin
            chk("byte_ready", 32'(byte_ready), 32'(ph == 1 || ph == 3));
            chk("mem_we", 32'(mem_we), 32'(ph == 2 && !rst));
            chk("busy", 32'(busy), 32'(ph != 0));
            chk("done", 32'(done), 32'(ph == 4));
`ifdef LOADER_CHECKSUM_EN
            chk("chk_err", 32'(chk_err), 32'(m_chk));
`endif
            if (ph == 2 && !rst) begin
                chk("mem_addr", 32'(mem_addr), 32'(m_widx * 4));
                chk("mem_wd", mem_wd, {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
            end
            if (mem_we === 1'b1) begin
                we_addrs.push_back(int'(mem_addr));
                we_datas.push_back(mem_wd);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        m_acc = 1'b0;
        if (rst) begin
            ph = 0; m_widx = 0; m_bytes.delete(); m_xor = '0; m_chk = 1'b0;
        end else begin
            case (ph)
                0: if (start) begin
                    m_cnt  = (int'(word_count) > MAXW) ? MAXW : int'(word_count);
                    m_widx = 0; m_bytes.delete(); m_xor = '0; m_chk = 1'b0;
                    ph = (m_cnt == 0) ? 4 : 1;
                end
                1: if (byte_valid) begin
                    m_bytes.push_back(byte_data);
                    m_xor = m_xor ^ byte_data;
                    m_acc = 1'b1;
                    if (m_bytes.size() == 4) ph = 2;
                end
                2: begin
                    m_bytes.delete();
                    if (m_widx + 1 == m_cnt) begin
                        m_widx = 0;
`ifdef LOADER_CHECKSUM_EN
                        ph = 3;
`else
                        ph = 4;
`endif
                    end else begin
                        m_widx++;
                        ph = 1;
                    end
                end
                3: if (byte_valid) begin
                    m_chk = (byte_data != m_xor);
                    m_acc = 1'b1;
                    ph = 4;
                end
                default: begin
                    ph = 0;
                    m_widx = 0;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One load: src bytes are offered in order, re-offered until the model accepts them.
    task automatic run_load(input int count, input logic [7:0] src[$], input int gap_pct,
                            input int gap_at, input int gap_len, input int rst_after, input bit noise);
        int idx = 0;
        int gap_left = 0;
        bit gapped = 1'b0;
        int budget = 20 * count + 60;
        we_addrs.delete(); we_datas.delete(); done_cnt = 0; done_cyc = -1;
        start = 1'b1;
        word_count = 11'(count);
        start_cyc = cyc;
        byte_valid = 1'b0;
        tick();
        start = 1'b0;
        while (1) begin
            if (m_acc) idx++;
            if (ph == 0) break;
            if (budget == 0) begin
                chk("load_timeout", 32'(ph), 32'd0);
                break;
            end
            budget--;
            if (rst_after >= 0 && idx == rst_after) begin
                rst = 1'b1;
                tick();
                chk("busy_after_rst", 32'(busy), 32'd0);
                chk("we_after_rst", 32'(mem_we), 32'd0);
                chk("wd_after_rst", mem_wd, 32'd0);
                chk("addr_after_rst", 32'(mem_addr), 32'd0);
                rst = 1'b0;
                byte_valid = 1'b0;
                tick();
                return;
            end
            start = noise && ($urandom_range(0, 4) == 0);
            word_count = 11'($urandom_range(0, 2047));
            if (idx == gap_at && !gapped) begin
                gapped = 1'b1;
                gap_left = gap_len;
            end
            byte_data = 8'($urandom);
            if (gap_left > 0) begin
                gap_left--;
                byte_valid = 1'b0;
            end else if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                byte_valid = 1'b0;
            end else if (idx < src.size()) begin
                byte_valid = 1'b1;
                byte_data = src[idx];
            end else begin
`ifdef LOADER_CHECKSUM_EN
                byte_valid = 1'b1;
`else
                byte_valid = 1'b0;
`endif
            end
            tick();
        end
        start = 1'b0;
        byte_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] s[$];
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // single word, back-to-back bytes
        s = '{8'h33, 8'h00, 8'h11, 8'h00};
        run_load(1, s, 0, -1, 0, -1, 1'b0);
        chk("w1_strobes", 32'(we_addrs.size()), 32'd1);
        if (we_addrs.size() == 1) begin
            chk("w1_addr", 32'(we_addrs[0]), 32'h0);
            chk("w1_data", we_datas[0], 32'h00110033);
        end
        chk("w1_done_lat", 32'(done_cyc - start_cyc), 32'd6);

        // three words continuous
        s.delete();
        for (int i = 0; i < 12; i++) s.push_back(8'($urandom));
        run_load(3, s, 0, -1, 0, -1, 1'b0);
        chk("w3_strobes", 32'(we_addrs.size()), 32'd3);
        for (int i = 0; i < 3 && i < we_addrs.size(); i++)
            chk("w3_addr", 32'(we_addrs[i]), 32'(i * 4));
        chk("w3_done_cnt", 32'(done_cnt), 32'd1);
        chk("w3_done_lat", 32'(done_cyc - start_cyc), 32'd16);

        // three-cycle gap between bytes 2 and 3
        s = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_load(1, s, 0, 2, 3, -1, 1'b0);
        chk("gap_strobes", 32'(we_addrs.size()), 32'd1);
        if (we_datas.size() >= 1) chk("gap_data", we_datas[0], 32'hD4C3B2A1);
        chk("gap_done_lat", 32'(done_cyc - start_cyc), 32'd9);

        // reset mid-word, then reload from address 0
        s = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        run_load(2, s, 0, -1, 0, 2, 1'b0);
        chk("rst_no_strobe", 32'(we_addrs.size()), 32'd0);
        s = '{8'h01, 8'h23, 8'h45, 8'h67};
        run_load(1, s, 0, -1, 0, -1, 1'b0);
        chk("reload_strobes", 32'(we_addrs.size()), 32'd1);
        if (we_addrs.size() >= 1) begin
            chk("reload_addr", 32'(we_addrs[0]), 32'h0);
            chk("reload_data", we_datas[0], 32'h67452301);
        end

        // zero-length load
        s.delete();
        run_load(0, s, 0, -1, 0, -1, 1'b0);
        chk("zero_strobes", 32'(we_addrs.size()), 32'd0);
        chk("zero_done_lat", 32'(done_cyc - start_cyc), 32'd1);
        chk("zero_done_cnt", 32'(done_cnt), 32'd1);

        // oversize count clamps to MAXW
        s.delete();
        for (int i = 0; i < 4 * MAXW; i++) s.push_back(8'($urandom));
        run_load(2000, s, 0, -1, 0, -1, 1'b0);
        chk("clamp_strobes", 32'(we_addrs.size()), 32'(MAXW));
        if (we_addrs.size() > 0) chk("clamp_last_addr", 32'(we_addrs[we_addrs.size() - 1]), 32'h0FFC);
        chk("clamp_done_cnt", 32'(done_cnt), 32'd1);

        // random loads with gaps and ignored starts while busy
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 5);
            s.delete();
            for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
            run_load(n, s, 30, -1, 0, -1, 1'b1);
            chk("rand_strobes", 32'(we_addrs.size()), 32'(n));
            chk("rand_done_cnt", 32'(done_cnt), 32'd1);
            repeat ($urandom_range(0, 3)) tick();
        end

`ifdef LOADER_CHECKSUM_EN
        s = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        run_load(1, s, 0, -1, 0, -1, 1'b0);
        chk("cksum_good", 32'(chk_err), 32'd0);
        s = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
        run_load(1, s, 0, -1, 0, -1, 1'b0);
        chk("cksum_bad", 32'(chk_err), 32'd1);
        repeat (4) tick();
        chk("cksum_hold", 32'(chk_err), 32'd1);
        s.delete();
        run_load(0, s, 0, -1, 0, -1, 1'b0);
        chk("cksum_clear", 32'(chk_err), 32'd0);
`endif

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024, meaning instruction memory depth in 32-bit words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-005 word_count  input  11  number of words to load; sampled with start.
REQ-006 byte_valid  input  1  source byte present on byte_data.
REQ-007 byte_data  input  8  incoming program byte.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_we  output  1  instruction memory write strobe.
REQ-010 mem_addr  output  16  byte address to instruction memory; bits [1:0] always 0.
REQ-011 mem_wd  output  32  write data word.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse at load completion.

Function
REQ-014 FSM states: IDLE, LOAD, WRITE, DONE (plus CHECK when REQ-029 applies).
REQ-015 IDLE -> LOAD on start with word_count != 0; IDLE -> DONE on start with word_count == 0.
REQ-016 word_count > MAX_WORDS is clamped to MAX_WORDS at capture.
REQ-017 start while busy is ignored; captured count is not altered.
REQ-018 LOAD: byte_ready = 1; a byte is accepted only when byte_valid && byte_ready in the same cycle.
REQ-019 Byte assembly little-endian: first accepted byte -> mem_wd[7:0], second -> [15:8], third -> [23:16], fourth -> [31:24].
REQ-020 On the fourth accepted byte, LOAD -> WRITE on the next edge; byte_valid gaps stall without losing assembled lanes.
REQ-021 WRITE lasts exactly one cycle: mem_we = 1, byte_ready = 0, mem_addr = word_idx × 4, mem_wd = assembled word.
REQ-022 After WRITE, word_idx increments; if new word_idx == captured count -> DONE (or CHECK), else -> LOAD with byte lane index 0.
REQ-023 DONE lasts one cycle with done = 1, then -> IDLE; word_idx returns to 0.
REQ-024 mem_we is asserted only in WRITE; mem_addr never exceeds (MAX_WORDS-1) × 4.
REQ-025 Latency: a word with no byte_valid gaps is written 4 cycles after its first byte is presented; a full N-word load without gaps takes 5N+1 cycles from start to done.

Reset
REQ-026 rst in any state forces IDLE next cycle; partially assembled word discarded; no mem_we issued in that or following cycle.
REQ-027 Reset values: byte_ready 0, mem_we 0, mem_addr 0, mem_wd 0, busy 0, done 0, word_idx 0, byte lane index 0.
REQ-028 rst takes priority over start in the same cycle.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN defined: adds output chk_err (1 bit); running XOR of all accepted program bytes; after final WRITE go to CHECK (byte_ready = 1) which accepts one checksum byte, sets chk_err = (byte != running XOR), then -> DONE.
REQ-030 chk_err holds until next accepted start or rst (reset value 0); running XOR cleared at start.
REQ-031 Macro undefined: no CHECK state, no chk_err port, WRITE of last word goes directly to DONE.

Verification
REQ-032 start, word_count=1, bytes 0x33,0x00,0x11,0x00 back-to-back -> single mem_we with mem_addr 0x0000, mem_wd 0x00110033, done 5 cycles after start+1.
REQ-033 word_count=3, continuous bytes -> mem_we at addresses 0x0000, 0x0004, 0x0008, exactly 3 strobes, done once.
REQ-034 byte_valid deasserted 3 cycles between bytes 2 and 3 -> same word value written, byte_ready stays 1 throughout the gap, no extra strobe.
REQ-035 rst asserted after 2 bytes of word 1 -> no mem_we, busy 0 next cycle; new start reloads from address 0x0000.
REQ-036 word_count=0 -> done pulse one cycle after start, no mem_we; word_count=2000 -> exactly 1024 writes, last at 0x0FFC.
REQ-037 With LOADER_CHECKSUM_EN: 1 word 0x01,0x02,0x04,0x08 then checksum 0x0F -> chk_err 0; checksum 0x0E -> chk_err 1, held until next start.
